// File: rtl/serial_frame_header_rx_pkg.sv
// serial_frame_header_rx_pkg: shared state encoding and default field widths for the serial transfer path
package serial_frame_header_rx_pkg;
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PORT  = 2'd1,
    COUNT = 2'd2,
    DATA  = 2'd3
  } state_e;
  localparam int DEF_PORT_W = 2;
  localparam int DEF_CNT_W  = 8;
endpackage

// File: rtl/serial_frame_header_rx_shift_in_reg.sv
// shift_in_reg: MSB-first serial-in shift register with shift enable and asynchronous clear
module shift_in_reg #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         sh,
  input  logic         d,
  output logic [W-1:0] q
);
  logic [W-1:0] sr_q, sr_d;
  always_comb sr_d = sh ? ((sr_q << 1) | W'(d)) : sr_q;
  always_ff @(posedge clk or posedge rst)
    if (rst) sr_q <= '0;
    else     sr_q <= sr_d;
  assign q = sr_q;
endmodule

// File: rtl/serial_frame_header_rx.sv
// serial_frame_header_rx: detects a start bit, shifts in port/length fields and enables the transfer stage for the data phase
module serial_frame_header_rx
  import serial_frame_header_rx_pkg::*;
#(
  parameter int PORT_W = DEF_PORT_W,
  parameter int CNT_W  = DEF_CNT_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              serIn,
  input  logic              done,
  output logic [CNT_W-1:0]  nt,
  output logic [PORT_W-1:0] port,
  output logic              en,
  output logic              busy,
  output logic              frame_err
);
  localparam int MAXW = (PORT_W > CNT_W) ? PORT_W : CNT_W;
  localparam int CW   = $clog2(MAXW) + 1;
  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          en_q, en_d, err_q, err_d;
  logic          sh_port, sh_nt, last_bit, nt_nonzero;
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    err_d      = 1'b0;
    sh_port    = state_q == PORT;
    sh_nt      = state_q == COUNT;
    last_bit   = cnt_q == CW'(sh_port ? PORT_W - 1 : CNT_W - 1);
    // the field value including the bit being sampled this edge
    nt_nonzero = ((nt << 1) | CNT_W'(serIn)) != '0;
    unique case (state_q)
      IDLE: begin
        state_d = serIn ? IDLE : PORT;
        cnt_d   = '0;
      end
      PORT: begin
        state_d = last_bit ? COUNT : PORT;
        cnt_d   = last_bit ? '0 : cnt_q + CW'(1);
      end
      COUNT: begin
        state_d = !last_bit ? COUNT : nt_nonzero ? DATA : IDLE;
        cnt_d   = last_bit ? '0 : cnt_q + CW'(1);
        err_d   = last_bit && !nt_nonzero;
      end
      DATA: state_d = done ? IDLE : DATA;
      default: state_d = IDLE;
    endcase
    en_d = state_d == DATA;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      en_q    <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      en_q    <= en_d;
      err_q   <= err_d;
    end
  shift_in_reg #(.W(PORT_W)) u_port (.clk(clk), .rst(rst), .sh(sh_port), .d(serIn), .q(port));
  shift_in_reg #(.W(CNT_W))  u_nt   (.clk(clk), .rst(rst), .sh(sh_nt),   .d(serIn), .q(nt));
  assign en        = en_q;
  assign busy      = state_q != IDLE;
  assign frame_err = err_q;
endmodule

// File: tb/tb_serial_frame_header_rx.sv
// tb_serial_frame_header_rx: directed and randomized frames checked against expectations derived from the frame fields
module tb_serial_frame_header_rx;
  localparam int PW = 2;
  localparam int CW = 8;
  logic          clk = 1'b0;
  logic          rst, serIn, done;
  logic [CW-1:0] nt;
  logic [PW-1:0] port;
  logic          en, busy, frame_err;
  int            checks = 0;
  int            errors = 0;

  serial_frame_header_rx #(.PORT_W(PW), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .serIn(serIn), .done(done),
    .nt(nt), .port(port), .en(en), .busy(busy), .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic s, input logic d);
    serIn = s;
    done  = d;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, ".en"}, en, 0);
    chk({tag, ".busy"}, busy, 0);
    chk({tag, ".err"}, frame_err, 0);
    chk({tag, ".nt"}, nt, 0);
    chk({tag, ".port"}, port, 0);
  endtask

  // Sends one complete frame; for nonzero length, 'nd' data edges follow with done on the last one.
  task automatic frame(input logic [PW-1:0] p, input logic [CW-1:0] n, input int nd);
    step(1'b0, 1'($urandom));
    chk("start.busy", busy, 1);
    chk("start.en", en, 0);
    for (int i = PW - 1; i >= 0; i--) begin
      step(p[i], 1'($urandom));
      chk("hdr_port.en", en, 0);
    end
    for (int i = CW - 1; i >= 0; i--) begin
      if (i == 0) begin
        chk("hdr_cnt.en", en, 0);
        chk("hdr_cnt.busy", busy, 1);
      end
      step(n[i], 1'($urandom));
    end
    if (n == 0) begin
      chk("zero.err", frame_err, 1);
      chk("zero.en", en, 0);
      chk("zero.busy", busy, 0);
      chk("zero.nt", nt, 0);
      chk("zero.port", port, 32'(p));
      step(1'b1, 1'b0);
      chk("zero.err_clear", frame_err, 0);
      chk("zero.en_after", en, 0);
    end else begin
      chk("hdr.en_rise", en, 1);
      chk("hdr.port", port, 32'(p));
      chk("hdr.nt", nt, 32'(n));
      chk("hdr.err", frame_err, 0);
      for (int d = 1; d <= nd; d++) begin
        step(1'($urandom), d == nd);
        if (d < nd) begin
          chk("data.en", en, 1);
          chk("data.busy", busy, 1);
          chk("data.nt", nt, 32'(n));
        end
      end
      chk("done.en", en, 0);
      chk("done.busy", busy, 0);
    end
  endtask

  initial begin
    rst = 1'b1; serIn = 1'b1; done = 1'b0;
    #3;
    chk_all_zero("reset");
    rst = 1'b0;
    for (int i = 0; i < 20; i++) begin
      step(1'b1, 1'($urandom));
      chk("idle.busy", busy, 0);
      chk("idle.en", en, 0);
      chk("idle.err", frame_err, 0);
    end
    frame(2'd2, 8'd3, 3);
    frame(2'd1, 8'd0, 0);
    step(1'b1, 1'b0);
    // abort a frame with nt=0xA5 after four count bits
    step(1'b0, 1'b0);
    step(1'b1, 1'b0);
    step(1'b1, 1'b0);
    for (int i = 7; i >= 4; i--) step(1'(8'hA5 >> i), 1'b0);
    chk("pre_rst.busy", busy, 1);
    #2 rst = 1'b1;
    #1 chk_all_zero("mid_rst");
    #1 rst = 1'b0;
    frame(2'd3, 8'hA5, 2);
    step(1'b1, 1'b0);
    frame(2'd1, 8'd1, 1);
    frame(2'd0, 8'd255, 4);
    for (int r = 0; r < 8; r++)
      frame(PW'($urandom), ($urandom_range(0, 3) == 0) ? 8'd0 : 8'($urandom_range(1, 255)),
            $urandom_range(1, 5));
    step(1'b1, 1'b0);
    #2 rst = 1'b1;
    #1 chk_all_zero("final_rst");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/serial_frame_header_rx.md
Name: serial_frame_header_rx

Overview:
Upstream stage of the serial transfer path. Watches the incoming serial line for a start bit, then shifts in a port-select field and a transfer-length field. It then enables the downstream counted transfer stage (inputs en, nt, done) for exactly the data phase. The data bits themselves pass straight through to the transfer stage; this block only frames them.

Parameters:
- PORT_W, default 2, width of the port-select field following the start bit.
- CNT_W, default 8, width of the length field; it drives the downstream nt input.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- rst  input  1  reset; asynchronous, active-high.
- serIn  input  1  serial line; idles at 1.
- done  input  1  end-of-transfer pulse from the downstream stage.
- nt  output  CNT_W  captured transfer length; stable while en=1.
- port  output  PORT_W  captured port select; stable while en=1.
- en  output  1  registered enable to the downstream stage; high for the whole data phase.
- busy  output  1  high in every state except IDLE.
- frame_err  output  1  one-cycle pulse when a frame with length 0 is discarded.

Behaviour:
- Reset, asynchronous with rst=1:
  - state goes to IDLE.
  - en=0, busy=0, frame_err=0, nt=0, port=0, bit counter=0.
  - Takes effect immediately, including mid-frame.
  - After rst falls, the first possible start detection is the next rising edge with serIn=0.
- States: IDLE, PORT, COUNT, DATA.
- IDLE:
  - serIn=1 at the edge: stay in IDLE.
  - serIn=0 at the edge (start bit): go to PORT and clear the bit counter.
  - done is ignored.
- PORT:
  - Each edge shifts serIn into port, MSB first.
  - After PORT_W bits, go to COUNT and clear the bit counter.
- COUNT:
  - Each edge shifts serIn into nt, MSB first.
  - On the CNT_W-th bit the assembled value is checked:
    - Nonzero: go to DATA and set en=1 at the same edge.
    - Zero: go to IDLE, en stays 0, frame_err pulses for one cycle. nt and port keep the zero-length values.
- DATA:
  - en=1 and serIn is ignored by this block.
  - done=1 at an edge: go to IDLE and set en=0 at that edge.
- Latency, with the start bit sampled at edge k:
  - port bits are sampled at edges k+1 .. k+PORT_W.
  - count bits are sampled at k+PORT_W+1 .. k+PORT_W+CNT_W.
  - en is high from edge k+PORT_W+CNT_W.
  - The first data bit is the one present on serIn before edge k+PORT_W+CNT_W+1.
- done handling:
  - done is ignored outside DATA.
  - A done pulse in the same cycle that en rises is not possible downstream and needs no special handling.
- Back-to-back frames: after DATA→IDLE at edge j, serIn=0 at edge j+1 starts a new frame. There is no mandatory idle gap.
- Bit counter:
  - Width is clog2(max(PORT_W, CNT_W)) + 1.
  - It never wraps within a field.
- No parity, stop bit or timeout.

Decomposition:
- Shared package holds:
  - state encoding constants: IDLE=2'd0, PORT=2'd1, COUNT=2'd2, DATA=2'd3.
  - default PORT_W and CNT_W constants, shared with the transfer stage so nt widths match.
- One natural sub-module, shift_in_reg:
  - parameterised width, MSB-first shift register with shift enable and asynchronous clear.
  - instantiated twice, once for port and once for nt.
- FSM and bit counter live in the top module.

Test Plan:
- Idle and reset:
  - serIn=1 for 20 cycles → busy=0, en=0, frame_err=0 throughout.
  - Reset asserted at any point → all outputs 0 immediately.
- Basic frame:
  - Stimulus: start 0, port bits 1,0, count bits 00000011, then 3 data bits; drive done=1 at the 3rd data edge.
  - Response: port=2 and nt=3 with en rising at edge k+10; en low after the done edge; busy low after the done edge.
- Zero length:
  - Stimulus: start 0, port 01, count 00000000.
  - Response: frame_err=1 for exactly one cycle at edge k+10; en never rises; state returns to IDLE.
- Reset mid-COUNT:
  - Stimulus: assert rst after 4 count bits of a frame with nt=0xA5.
  - Response: en=0, nt=0 and port=0 immediately. A full subsequent frame with nt=0xA5, port=3 decodes correctly.
- Back-to-back frames:
  - Stimulus: frame 1 with nt=1, port=1; serIn=0 on the edge right after done; frame 2 with nt=255, port=0.
  - Response: both decoded. en is low for exactly the frame-2 header cycles. en stays high until done in frame 2.
- done outside DATA and simultaneous events:
  - Pulse done during PORT and COUNT → no state change.
  - serIn=0 during DATA → no restart.
